// File: rtl/axi_wr_burst_master.sv
// axi_wr_burst_master: AXI4 INCR write-burst initiator draining a ready/valid stream,
// one burst outstanding, result reported on a one-cycle done pulse.
module axi_wr_burst_master #(
    parameter int ADW  = 32,
    parameter int DDW  = 32,
    parameter int LENW = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADW-1:0]    cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              din_vld,
    output logic              din_rdy,
    input  logic [DDW-1:0]    din,
    output logic [ADW-1:0]    awaddr,
    output logic [LENW-1:0]   awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DDW-1:0]    wdata,
    output logic [DDW/8-1:0]  wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              done_vld,
    output logic              done_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t          state;
    logic [LENW-1:0] cnt;
    logic            beat;
    logic            unused_bresp;
    assign awsize       = 3'($clog2(DDW / 8));
    assign awburst      = 2'b01;
    assign wdata        = din;
    assign wstrb        = '1;
    // W channel is a straight pass-through of the stream, gated to the DATA phase
    assign wvalid       = (state == DATA) && din_vld;
    assign din_rdy      = (state == DATA) && wready;
    assign wlast        = (state == DATA) && (cnt == awlen);
    assign beat         = wvalid && wready;
    assign unused_bresp = bresp[0];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cmd_rdy  <= 1'b1;
            awvalid  <= 1'b0;
            bready   <= 1'b0;
            done_vld <= 1'b0;
            done_err <= 1'b0;
            cnt      <= '0;
            awaddr   <= '0;
            awlen    <= '0;
        end else if (clr) begin
            state    <= IDLE;
            cmd_rdy  <= 1'b1;
            awvalid  <= 1'b0;
            bready   <= 1'b0;
            done_vld <= 1'b0;
            done_err <= 1'b0;
            cnt      <= '0;
            awaddr   <= '0;
            awlen    <= '0;
        end else begin
            done_vld <= 1'b0;
            done_err <= 1'b0;
            case (state)
                IDLE: if (cmd_vld) begin
                    awaddr  <= cmd_addr;
                    awlen   <= cmd_len;
                    awvalid <= 1'b1;
                    cmd_rdy <= 1'b0;
                    state   <= ADDR;
                end
                ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    state   <= DATA;
                end
                DATA: if (beat) begin
                    cnt <= wlast ? '0 : cnt + 1'b1;
                    if (wlast) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: if (bvalid) begin
                    bready   <= 1'b0;
                    done_vld <= 1'b1;
                    done_err <= bresp[1];
                    cmd_rdy  <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
